// File: rtl/mux_n_1_rr_pkg.sv
// mux_n_1_rr_pkg: shared mode encodings for the N:1 mux.
package mux_n_1_rr_pkg;
  localparam logic MUX_MODE_FIXED = 1'b0;
  localparam logic MUX_MODE_RR    = 1'b1;
endpackage

// File: rtl/mux_n_1_rr_arb.sv
// rr_arb_n: combinational rotating-priority finder. It scans ptr+1 .. ptr (mod N)
// and returns the first requester, one-hot plus index.
module rr_arb_n #(
  parameter int N = 8,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);
  logic found;
  int c;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    c = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        gnt_idx = PW'(c);
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/mux_n_1_rr.sv
// mux_n_1_rr: N:1 valid/ready multiplexer with a one-word registered output stage,
// selected by an external index or by round-robin arbitration.
module mux_n_1_rr
  import mux_n_1_rr_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = 16,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);
  logic [NUM_CH-1:0] rr_gnt, fix_gnt, gnt;
  logic [SEL_W-1:0]  rr_idx, idx, ptr_q, ptr_d, ch_q, ch_d;
  logic [WIDTH-1:0]  sel_data, data_q, data_d;
  logic              valid_q, valid_d, load_en, xfer;

  rr_arb_n #(.N(NUM_CH)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Shifting past the top bit leaves no grant when sel is out of range.
  assign fix_gnt  = in_valid & (NUM_CH'(1) << sel);
  assign gnt      = (mode == MUX_MODE_RR) ? rr_gnt : fix_gnt;
  assign idx      = (mode == MUX_MODE_RR) ? rr_idx : sel;
  assign sel_data = in_data[int'(idx)*WIDTH +: WIDTH];
  assign load_en  = !valid_q || out_ready;
  assign in_ready = (load_en && !rst) ? gnt : '0;
  assign xfer     = |in_ready;

  always_comb begin
    valid_d = load_en ? xfer : valid_q;
    data_d  = xfer ? sel_data : data_q;
    ch_d    = xfer ? idx : ch_q;
    ptr_d   = xfer ? idx : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= SEL_W'(NUM_CH-1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;
endmodule

// File: tb/tb_mux_n_1_rr.sv
// tb_mux_n_1_rr: 8-channel and 5-channel instances driven in lockstep and checked
// against a transaction-level model of the grant rules and the output word.
module tb_mux_n_1_rr;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mode8 = 1'b0, mode5 = 1'b0, out_ready = 1'b1;
  logic [2:0]   sel8 = '0, sel5 = '0;
  logic [127:0] in_data = '0;
  logic [7:0]   in_valid = '0;
  logic [7:0]   rdy8;
  logic [4:0]   rdy5;
  logic [15:0]  od8, od5;
  logic         ov8, ov5;
  logic [2:0]   oc8, oc5;
  int checks = 0, errors = 0;
  // model: held word and last served channel per instance (0 = 8ch, 1 = 5ch)
  logic mv[2];
  logic [15:0] md[2];
  int mc[2], mp[2], gn[2];
  logic [31:0] exp_rdy[2];

  always #5 clk = ~clk;

  mux_n_1_rr #(.NUM_CH(8), .WIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .mode(mode8), .sel(sel8), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy8), .out_data(od8), .out_valid(ov8),
    .out_ch(oc8), .out_ready(out_ready));

  mux_n_1_rr #(.NUM_CH(5), .WIDTH(16)) dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .sel(sel5), .in_data(in_data[79:0]),
    .in_valid(in_valid[4:0]), .in_ready(rdy5), .out_data(od5), .out_valid(ov5),
    .out_ch(oc5), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(int d);
    int n = d ? 5 : 8;
    logic m = d ? mode5 : mode8;
    int s = d ? int'(sel5) : int'(sel8);
    if (!m) return (s < n && in_valid[s]) ? s : -1;
    for (int k = 1; k <= n; k++) begin
      int c = (mp[d] + k) % n;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0;
      mp[d] = d ? 4 : 7;
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
  endtask

  // Called just after the falling edge with inputs already driven.
  task automatic cycle();
    for (int d = 0; d < 2; d++) begin
      gn[d] = (rst || !(!mv[d] || out_ready)) ? -1 : pick(d);
      exp_rdy[d] = (gn[d] < 0) ? 32'd0 : (32'd1 << gn[d]);
    end
    #1;
    chk("in_ready8", 32'(rdy8), exp_rdy[0]);
    chk("in_ready5", 32'(rdy5), exp_rdy[1]);
    chk("out_valid8", 32'(ov8), 32'(mv[0]));
    chk("out_valid5", 32'(ov5), 32'(mv[1]));
    if (mv[0]) begin
      chk("out_data8", 32'(od8), 32'(md[0]));
      chk("out_ch8", 32'(oc8), 32'(mc[0]));
    end
    if (mv[1]) begin
      chk("out_data5", 32'(od5), 32'(md[1]));
      chk("out_ch5", 32'(oc5), 32'(mc[1]));
    end
    @(posedge clk);
    if (rst) model_reset();
    else for (int d = 0; d < 2; d++) begin
      if (gn[d] >= 0) begin
        mv[d] = 1'b1;
        md[d] = in_data[gn[d]*16 +: 16];
        mc[d] = gn[d];
        mp[d] = gn[d];
      end else if (out_ready) mv[d] = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // reset with every channel requesting
    in_valid = 8'hFF;
    mode8 = 1'b1;
    mode5 = 1'b1;
    cycle();
    chk("rst_out_data", 32'(od8), 32'd0);
    chk("rst_out_ch", 32'(oc8), 32'd0);
    rst = 1'b0;
    randomize_data();
    cycle();
    // fixed select on channel 5, every channel valid
    mode8 = 1'b0;
    mode5 = 1'b0;
    sel8 = 3'd5;
    sel5 = 3'd3;
    for (int i = 0; i < 6; i++) begin
      randomize_data();
      cycle();
    end
    // round-robin over a sparse request pattern: 0,2,5,7,...
    mode8 = 1'b1;
    mode5 = 1'b1;
    in_valid = 8'b1010_0101;
    for (int i = 0; i < 10; i++) begin
      randomize_data();
      cycle();
    end
    // backpressure for three cycles, then release
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_data();
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_data();
      cycle();
    end
    // out-of-range select on the 5-channel build, then resume round-robin
    in_valid = 8'hFF;
    mode5 = 1'b0;
    sel5 = 3'd2;
    randomize_data();
    cycle();
    sel5 = 3'd6;
    for (int i = 0; i < 3; i++) begin
      randomize_data();
      cycle();
    end
    mode5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      randomize_data();
      cycle();
    end
    // reset while a word is held under backpressure
    mode8 = 1'b1;
    randomize_data();
    cycle();
    out_ready = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    chk("async_rst_valid8", 32'(ov8), 32'd0);
    chk("async_rst_valid5", 32'(ov5), 32'd0);
    model_reset();
    @(negedge clk);
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    randomize_data();
    cycle();
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      mode8 = 1'($urandom);
      mode5 = 1'($urandom);
      sel8 = 3'($urandom);
      sel5 = 3'($urandom);
      in_valid = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      randomize_data();
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
